// File: rtl/pb_intc.sv
// pb_intc: 8-source rising-edge interrupt controller mapped into a 4-register KCPSM6 port window.
// Optional macro PB_INTC_ACK_TIMEOUT_EN adds an acknowledge timeout that sets CTRL.TOF.
module pb_intc #(
  parameter logic [7:0] BASE_ADDR = 8'hE0
) (
  input  logic       clk_sys,
  input  logic       reset_sys,
  input  logic [7:0] irq_src,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_data,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] src_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] in_data_q, in_data_d;
  logic [2:0] vec_q, vec_d;
  logic       gen_q, gen_d;
  logic       irq_q, irq_d;

  logic [7:0] rise, eligible, wr_clr, ack_clr, rdata;
  logic [2:0] first_idx;
  logic       win_sel, wr_pend, wr_mask, wr_vec, wr_ctrl;
  logic       timeout, tof_rd;
  logic       unused_rd;

  // No register defines a read side effect.
  assign unused_rd = read_strobe;

  assign win_sel = (port_id[7:2] == BASE_ADDR[7:2]);
  assign wr_pend = write_strobe && win_sel && (port_id[1:0] == 2'd0);
  assign wr_mask = write_strobe && win_sel && (port_id[1:0] == 2'd1);
  assign wr_vec  = write_strobe && win_sel && (port_id[1:0] == 2'd2);
  assign wr_ctrl = write_strobe && win_sel && (port_id[1:0] == 2'd3);

  assign rise     = irq_src & ~src_q;
  assign eligible = gen_q ? (pend_q & mask_q) : 8'h00;

  // Bit 0 has the highest priority, so scan downwards and keep the last hit.
  always_comb begin
    first_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) first_idx = 3'(i);
    end
  end

`ifdef PB_INTC_ACK_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       tof_q, tof_d;
  logic       tof_set;

  assign timeout = (state_q == REQ) && (cnt_q == 8'd254);
  assign tof_set = timeout && gen_q && !interrupt_ack;
  assign tof_rd  = tof_q;

  always_comb begin
    cnt_d = 8'd0;
    if ((state_q == REQ) && (state_d == REQ)) cnt_d = cnt_q + 8'd1;
    tof_d = (tof_q & ~(wr_ctrl & out_port[7])) | tof_set;
  end

  always_ff @(posedge clk_sys) begin
    if (reset_sys) begin
      cnt_q <= 8'd0;
      tof_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tof_q <= tof_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign tof_rd  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    irq_d   = 1'b0;
    vec_d   = vec_q;
    ack_clr = 8'h00;
    case (state_q)
      IDLE: begin
        if (eligible != 8'h00) begin
          state_d = REQ;
          vec_d   = first_idx;
          irq_d   = 1'b1;
        end
      end
      REQ: begin
        if (!gen_q) begin
          state_d = IDLE;
        end else if (interrupt_ack) begin
          state_d = SERVICE;
          ack_clr = 8'h01 << vec_q;
        end else if (timeout) begin
          state_d = IDLE;
        end else begin
          irq_d = 1'b1;
        end
      end
      SERVICE: begin
        if (wr_vec) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge wins over a same-cycle W1C or acknowledge clear.
  always_comb begin
    wr_clr = wr_pend ? out_port : 8'h00;
    pend_d = (pend_q & ~(wr_clr | ack_clr)) | rise;
    mask_d = wr_mask ? out_port : mask_q;
    gen_d  = wr_ctrl ? out_port[0] : gen_q;
    case (port_id[1:0])
      2'd0:    rdata = pend_q;
      2'd1:    rdata = mask_q;
      2'd2:    rdata = {(state_q == SERVICE), 4'b0000, vec_q};
      default: rdata = {tof_rd, 6'b000000, gen_q};
    endcase
    in_data_d = win_sel ? rdata : 8'h00;
  end

  always_ff @(posedge clk_sys) begin
    if (reset_sys) begin
      state_q   <= IDLE;
      src_q     <= irq_src;
      pend_q    <= 8'h00;
      mask_q    <= 8'h00;
      gen_q     <= 1'b0;
      vec_q     <= 3'd0;
      irq_q     <= 1'b0;
      in_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      src_q     <= irq_src;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      gen_q     <= gen_d;
      vec_q     <= vec_d;
      irq_q     <= irq_d;
      in_data_q <= in_data_d;
    end
  end

  assign in_data   = in_data_q;
  assign interrupt = irq_q;

endmodule
